// File: rtl/output_module_pkg.sv
// Shared constants and helpers for the router output port:
// link geometry, direction codes and the round-robin index wrap.
package output_module_pkg;

  localparam int DATA_W  = 64;
  localparam int NUM_IN  = 5;
  localparam int CREDITS = 32;
  localparam int CNT_W   = 6;
  localparam int PTR_W   = 3;

  typedef enum logic [2:0] {
    DIR_N       = 3'd0,
    DIR_S       = 3'd1,
    DIR_E       = 3'd2,
    DIR_W       = 3'd3,
    DIR_L       = 3'd4,
    DIR_INVALID = 3'd7
  } dir_e;

  // (base + ofs) mod NUM_IN; both operands are already below NUM_IN.
  function automatic logic [PTR_W-1:0] rr_wrap(input logic [PTR_W-1:0] base,
                                               input logic [PTR_W-1:0] ofs);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + {1'b0, ofs};
    if (sum >= (PTR_W+1)'(NUM_IN)) sum = sum - (PTR_W+1)'(NUM_IN);
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/output_module_if.sv
// Bundle between the output port, the five requesting input VC buffers and the link.
interface output_module_if;
  import output_module_pkg::*;

  logic [NUM_IN-1:0]        req;
  logic [NUM_IN*DATA_W-1:0] data_in;
  logic [NUM_IN-1:0]        grant;
  logic [DATA_W-1:0]        data_out;
  logic                     valid_out;
  logic                     credit_in;

  modport master (
    output req, data_in, credit_in,
    input  grant, data_out, valid_out
  );

  modport slave (
    input  req, data_in, credit_in,
    output grant, data_out, valid_out
  );

endinterface

// File: rtl/output_module_credit_counter.sv
// Credit count for the downstream VC buffer; saturates at full depth and
// raises a sticky error when a credit returns with nothing outstanding.
module output_module_credit_counter
  import output_module_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             consume,
  input  logic             credit_in,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             err
);

  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg, err_next;
  logic             full;

  assign full = (count_reg == CNT_W'(CREDITS));

  always_comb begin
    count_next = count_reg;
    err_next   = err_reg;
    case ({consume, credit_in})
      2'b10:   count_next = count_reg - CNT_W'(1);
      2'b01: begin
        if (full) err_next = 1'b1;
        else      count_next = count_reg + CNT_W'(1);
      end
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= CNT_W'(CREDITS);
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  assign count   = count_reg;
  assign nonzero = (count_reg != '0);
  assign err     = err_reg;

endmodule

// File: rtl/output_module.sv
// Router output port: credit-gated round-robin over the five input heads,
// registered flit onto the link one cycle after the grant.
module output_module
  import output_module_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        port,
  output_module_if.slave    bus,
  output logic [CNT_W-1:0]  credits,
  output logic              credit_err
);

  logic [NUM_IN-1:0] eff_req;
  logic [DATA_W-1:0] flits [NUM_IN];
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic [NUM_IN-1:0] grant_comb;
  logic              any_grant;
  logic              credit_nz;
  logic [DATA_W-1:0] data_out_reg;
  logic              valid_out_reg;

  // No U-turns; an illegal port code matches no index so nothing is masked.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      assign eff_req[gi] = bus.req[gi] & (port != PTR_W'(gi));
      assign flits[gi]   = bus.data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = rr_wrap(ptr_reg, PTR_W'(k));
      if (!win_found && eff_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Gated by the registered count only; a same-cycle credit return cannot help.
  always_comb begin
    grant_comb = '0;
    if (win_found && credit_nz && reset) grant_comb[win_idx] = 1'b1;
  end

  assign any_grant = |grant_comb;
  assign ptr_next  = any_grant ? rr_wrap(win_idx, PTR_W'(1)) : ptr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg       <= '0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      valid_out_reg <= any_grant;
      if (any_grant) data_out_reg <= flits[win_idx];
    end
  end

  output_module_credit_counter u_credit (
    .clk       (clk),
    .reset     (reset),
    .consume   (any_grant),
    .credit_in (bus.credit_in),
    .count     (credits),
    .nonzero   (credit_nz),
    .err       (credit_err)
  );

  assign bus.grant     = grant_comb;
  assign bus.data_out  = data_out_reg;
  assign bus.valid_out = valid_out_reg;

endmodule
